// File: rtl/cpu_control_fsm_if.sv
// Unified-memory handshake between the control FSM (master) and the memory (slave).
// The control unit drives the request/address selects; memory answers with ready.
interface cpu_control_fsm_if;
   logic       mem_req;
   logic       mem_we;
   logic [1:0] mem_addr_sel;
   logic       mem_ready;

   modport master (output mem_req, output mem_we, output mem_addr_sel, input mem_ready);
   modport slave  (input mem_req, input mem_we, input mem_addr_sel, output mem_ready);
endinterface

// File: rtl/cpu_control_fsm.sv
// Multi-cycle control unit for the 32-bit CPU datapath: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK
// sequencing, memory handshake with wait-state timeout, and all datapath strobes/selects.
module cpu_control_fsm #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   cpu_control_fsm_if.master        mem,
   input  logic [2:0]               opcode_i,
   input  logic [4:0]               funct_i,
   input  logic [1:0]               funct2_i,
   input  logic                     pc_op_i,
   input  logic                     zero_i,
   input  logic                     neg_i,
   output logic                     ir_write_o,
   output logic                     pc_write_o,
   output logic [1:0]               pc_src_o,
   output logic                     rb_read1_o,
   output logic                     rb_read2_o,
   output logic                     rb_write_o,
   output logic [1:0]               wb_sel_o,
   output logic [3:0]               alu_op_o,
   output logic                     alu_src_imm_o,
   output logic [1:0]               sp_ctl_o,
   output logic [2:0]               state_o,
   output logic                     halted_o,
   output logic                     bus_error_o,
   output logic                     illegal_o
);
   typedef enum logic [2:0] {
      FETCH     = 3'd0,
      DECODE    = 3'd1,
      EXECUTE   = 3'd2,
      MEMORY    = 3'd3,
      WRITEBACK = 3'd4,
      HALT      = 3'd5
   } state_t;

   localparam logic [2:0] OP_ALU  = 3'b000;
   localparam logic [2:0] OP_LDST = 3'b001;
   localparam logic [2:0] OP_BR   = 3'b010;
   localparam logic [2:0] OP_STK  = 3'b011;
   localparam logic [2:0] OP_MOV  = 3'b100;
   localparam logic [2:0] OP_PC   = 3'b101;
   localparam logic [2:0] OP_SALU = 3'b110;
   localparam logic [2:0] OP_ILL  = 3'b111;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       opcode_q, opcode_d;
   logic [4:0]       funct_q, funct_d;
   logic [1:0]       funct2_q, funct2_d;
   logic             bus_error_q, bus_error_d;

   logic             mem_req, mem_we;
   logic [1:0]       mem_addr_sel;
   logic             ready;

   assign ready = mem.mem_ready;

   // Branch condition on the latched subtype: always, zero, negative, non-zero.
   function automatic logic br_taken(input logic [1:0] f2, input logic z, input logic n);
      case (f2)
         2'b00:   br_taken = 1'b1;
         2'b01:   br_taken = z;
         2'b10:   br_taken = n;
         default: br_taken = !z;
      endcase
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= FETCH;
         cnt_q       <= '0;
         opcode_q    <= '0;
         funct_q     <= '0;
         funct2_q    <= '0;
         bus_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         opcode_q    <= opcode_d;
         funct_q     <= funct_d;
         funct2_q    <= funct2_d;
         bus_error_q <= bus_error_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = '0;
      opcode_d      = opcode_q;
      funct_d       = funct_q;
      funct2_d      = funct2_q;
      bus_error_d   = bus_error_q;
      ir_write_o    = 1'b0;
      pc_write_o    = 1'b0;
      pc_src_o      = 2'd0;
      rb_read1_o    = 1'b0;
      rb_read2_o    = 1'b0;
      rb_write_o    = 1'b0;
      wb_sel_o      = 2'd0;
      alu_op_o      = 4'd0;
      alu_src_imm_o = 1'b0;
      sp_ctl_o      = 2'b00;
      halted_o      = 1'b0;
      illegal_o     = 1'b0;
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      mem_addr_sel  = 2'd0;

      // Strobes are forced low for as long as reset is held, not just until the next edge.
      if (!rst) begin
         case (state_q)
            FETCH: begin
               mem_req = 1'b1;
               if (ready) begin
                  ir_write_o = 1'b1;
                  pc_write_o = 1'b1;
                  state_d    = DECODE;
               end
            end
            DECODE: begin
               rb_read1_o = 1'b1;
               rb_read2_o = 1'b1;
               opcode_d   = opcode_i;
               funct_d    = funct_i;
               funct2_d   = funct2_i;
               case (opcode_i)
                  OP_PC:   state_d = pc_op_i ? FETCH : HALT;
                  OP_ILL: begin
                     illegal_o = 1'b1;
                     state_d   = FETCH;
                  end
                  default: state_d = EXECUTE;
               endcase
            end
            EXECUTE: begin
               state_d = FETCH;
               case (opcode_q)
                  OP_ALU: begin
                     alu_op_o      = funct_q[3:0];
                     alu_src_imm_o = funct_q[4];
                     state_d       = WRITEBACK;
                  end
                  OP_LDST: begin
                     alu_src_imm_o = 1'b1;
                     state_d       = MEMORY;
                  end
                  OP_BR: begin
                     if (br_taken(funct2_q, zero_i, neg_i)) begin
                        pc_write_o = 1'b1;
                        pc_src_o   = 2'd1;
                     end
                  end
                  OP_STK: begin
                     // PUSH/CALL pre-decrement SP; POP/RET address the current top.
                     if (!funct2_q[0]) sp_ctl_o = 2'b10;
                     state_d = MEMORY;
                  end
                  OP_MOV:  state_d = WRITEBACK;
                  OP_SALU: begin
                     alu_op_o      = funct_q[3:0];
                     alu_src_imm_o = 1'b1;
                     sp_ctl_o      = 2'b11;
                  end
                  default: state_d = FETCH;
               endcase
            end
            MEMORY: begin
               mem_req      = 1'b1;
               mem_addr_sel = (opcode_q == OP_LDST) ? 2'd1 : 2'd2;
               mem_we       = (opcode_q == OP_LDST) ? funct_q[0] : !funct2_q[0];
               if (ready) begin
                  if (mem_we) begin
                     state_d = FETCH;
                     if (opcode_q == OP_STK && funct2_q == 2'b10) begin
                        pc_write_o = 1'b1;
                        pc_src_o   = 2'd1;
                     end
                  end else if (opcode_q == OP_STK && funct2_q == 2'b11) begin
                     pc_write_o = 1'b1;
                     pc_src_o   = 2'd2;
                     sp_ctl_o   = 2'b01;
                     state_d    = FETCH;
                  end else begin
                     if (opcode_q == OP_STK) sp_ctl_o = 2'b01;
                     state_d = WRITEBACK;
                  end
               end
            end
            WRITEBACK: begin
               rb_write_o = 1'b1;
               case (opcode_q)
                  OP_LDST, OP_STK: wb_sel_o = 2'd1;
                  OP_MOV:          wb_sel_o = 2'd2;
                  default:         wb_sel_o = 2'd0;
               endcase
               state_d = FETCH;
            end
            HALT:    halted_o = 1'b1;
            default: state_d = FETCH;
         endcase

         // A ready arriving on the last allowed cycle completes the access instead of faulting.
         if (mem_req && !ready) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d     = HALT;
               bus_error_d = 1'b1;
            end
         end
      end
   end

   assign mem.mem_req      = mem_req;
   assign mem.mem_we       = mem_we;
   assign mem.mem_addr_sel = mem_addr_sel;
   assign state_o          = state_q;
   assign bus_error_o      = bus_error_q;
endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed-vector bench for cpu_control_fsm: stimulus pushes the expected per-cycle
// strobe vector into a queue; a monitor on the falling edge pops and compares.
module tb_cpu_control_fsm;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] opcode = '0;
   logic [4:0] funct = '0;
   logic [1:0] funct2 = '0;
   logic       pc_op = 1'b0;
   logic       zero = 1'b0;
   logic       neg = 1'b0;
   logic       ir_write, pc_write, rb_read1, rb_read2, rb_write, alu_src_imm;
   logic       halted, bus_error, illegal;
   logic [1:0] pc_src, wb_sel, sp_ctl;
   logic [3:0] alu_op;
   logic [2:0] state;

   logic [2:0] p_op = '0;
   logic [4:0] p_fn = '0;
   logic [1:0] p_f2 = '0;
   logic       p_pc = 1'b0;
   logic       p_z = 1'b0;
   logic       p_n = 1'b0;

   typedef struct {
      string       nm;
      logic [25:0] v;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;

   logic [25:0] E_FETCH, E_DEC, E_WAITF;

   cpu_control_fsm_if mif();

   cpu_control_fsm #(.MEM_TIMEOUT(16), .CNT_W(5)) dut (
      .clk           (clk),
      .rst           (rst),
      .mem           (mif),
      .opcode_i      (opcode),
      .funct_i       (funct),
      .funct2_i      (funct2),
      .pc_op_i       (pc_op),
      .zero_i        (zero),
      .neg_i         (neg),
      .ir_write_o    (ir_write),
      .pc_write_o    (pc_write),
      .pc_src_o      (pc_src),
      .rb_read1_o    (rb_read1),
      .rb_read2_o    (rb_read2),
      .rb_write_o    (rb_write),
      .wb_sel_o      (wb_sel),
      .alu_op_o      (alu_op),
      .alu_src_imm_o (alu_src_imm),
      .sp_ctl_o      (sp_ctl),
      .state_o       (state),
      .halted_o      (halted),
      .bus_error_o   (bus_error),
      .illegal_o     (illegal)
   );

   always #5 clk = ~clk;

   // Field order: ir pw pc_src rd1 rd2 rw wb_sel alu_op imm req we addr_sel sp state halted buserr illegal
   function automatic logic [25:0] mk(int ir, int pw, int ps, int r1, int r2, int rw, int wbs,
                                      int aop, int imm, int req, int we, int as, int sp,
                                      int st, int hl, int be, int il);
      return {1'(ir), 1'(pw), 2'(ps), 1'(r1), 1'(r2), 1'(rw), 2'(wbs), 4'(aop), 1'(imm),
              1'(req), 1'(we), 2'(as), 2'(sp), 3'(st), 1'(hl), 1'(be), 1'(il)};
   endfunction

   task automatic ir(int op, int fn, int f2, int pc);
      p_op = 3'(op);
      p_fn = 5'(fn);
      p_f2 = 2'(f2);
      p_pc = 1'(pc);
   endtask

   task automatic step(string nm, int r, int rdy, logic [25:0] ex);
      exp_t e;
      @(posedge clk);
      #1;
      rst            = 1'(r);
      mif.mem_ready  = 1'(rdy);
      opcode         = p_op;
      funct          = p_fn;
      funct2         = p_f2;
      pc_op          = p_pc;
      zero           = p_z;
      neg            = p_n;
      e.nm           = nm;
      e.v            = ex;
      q.push_back(e);
   endtask

   always @(negedge clk) begin
      logic [25:0] act;
      exp_t        e;
      if (q.size() > 0) begin
         e   = q.pop_front();
         act = {ir_write, pc_write, pc_src, rb_read1, rb_read2, rb_write, wb_sel, alu_op,
                alu_src_imm, mif.mem_req, mif.mem_we, mif.mem_addr_sel, sp_ctl, state,
                halted, bus_error, illegal};
         checks++;
         if (act !== e.v) begin
            errors++;
            $display("FAIL %s: got %b expected %b", e.nm, act, e.v);
         end
      end
   end

   initial begin
      mif.mem_ready = 1'b1;
      E_FETCH = mk(1,1,0, 0,0,0,0, 0,0, 1,0,0, 0, 0,0,0,0);
      E_DEC   = mk(0,0,0, 1,1,0,0, 0,0, 0,0,0, 0, 1,0,0,0);
      E_WAITF = mk(0,0,0, 0,0,0,0, 0,0, 1,0,0, 0, 0,0,0,0);

      step("rst0", 1, 1, '0);
      step("rst1", 1, 1, '0);

      ir(0, 5'b00011, 0, 0);
      step("add_f", 0, 1, E_FETCH);
      step("add_d", 0, 1, E_DEC);
      step("add_e", 0, 1, mk(0,0,0, 0,0,0,0, 3,0, 0,0,0, 0, 2,0,0,0));
      step("add_w", 0, 1, mk(0,0,0, 0,0,1,0, 0,0, 0,0,0, 0, 4,0,0,0));

      ir(1, 0, 0, 0);
      step("ld_f", 0, 1, E_FETCH);
      step("ld_d", 0, 1, E_DEC);
      step("ld_e", 0, 1, mk(0,0,0, 0,0,0,0, 0,1, 0,0,0, 0, 2,0,0,0));
      for (int i = 0; i < 3; i++)
         step("ld_mwait", 0, 0, mk(0,0,0, 0,0,0,0, 0,0, 1,0,1, 0, 3,0,0,0));
      step("ld_m", 0, 1, mk(0,0,0, 0,0,0,0, 0,0, 1,0,1, 0, 3,0,0,0));
      step("ld_w", 0, 1, mk(0,0,0, 0,0,1,1, 0,0, 0,0,0, 0, 4,0,0,0));

      ir(1, 1, 0, 0);
      step("st_f", 0, 1, E_FETCH);
      step("st_d", 0, 1, E_DEC);
      step("st_e", 0, 1, mk(0,0,0, 0,0,0,0, 0,1, 0,0,0, 0, 2,0,0,0));
      step("st_m", 0, 1, mk(0,0,0, 0,0,0,0, 0,0, 1,1,1, 0, 3,0,0,0));

      ir(2, 0, 1, 0);
      p_z = 1'b1;
      step("bz1_f", 0, 1, E_FETCH);
      step("bz1_d", 0, 1, E_DEC);
      step("bz1_e", 0, 1, mk(0,1,1, 0,0,0,0, 0,0, 0,0,0, 0, 2,0,0,0));
      p_z = 1'b0;
      step("bz0_f", 0, 1, E_FETCH);
      step("bz0_d", 0, 1, E_DEC);
      step("bz0_e", 0, 1, mk(0,0,0, 0,0,0,0, 0,0, 0,0,0, 0, 2,0,0,0));
      ir(2, 0, 3, 0);
      step("bnz_f", 0, 1, E_FETCH);
      step("bnz_d", 0, 1, E_DEC);
      step("bnz_e", 0, 1, mk(0,1,1, 0,0,0,0, 0,0, 0,0,0, 0, 2,0,0,0));

      ir(3, 0, 0, 0);
      step("push_f", 0, 1, E_FETCH);
      step("push_d", 0, 1, E_DEC);
      step("push_e", 0, 1, mk(0,0,0, 0,0,0,0, 0,0, 0,0,0, 2, 2,0,0,0));
      step("push_m", 0, 1, mk(0,0,0, 0,0,0,0, 0,0, 1,1,2, 0, 3,0,0,0));

      ir(3, 0, 3, 0);
      step("ret_f", 0, 1, E_FETCH);
      step("ret_d", 0, 1, E_DEC);
      step("ret_e", 0, 1, mk(0,0,0, 0,0,0,0, 0,0, 0,0,0, 0, 2,0,0,0));
      step("ret_m", 0, 1, mk(0,1,2, 0,0,0,0, 0,0, 1,0,2, 1, 3,0,0,0));

      ir(3, 0, 2, 0);
      step("call_f", 0, 1, E_FETCH);
      step("call_d", 0, 1, E_DEC);
      step("call_e", 0, 1, mk(0,0,0, 0,0,0,0, 0,0, 0,0,0, 2, 2,0,0,0));
      step("call_m", 0, 1, mk(0,1,1, 0,0,0,0, 0,0, 1,1,2, 0, 3,0,0,0));

      ir(3, 0, 1, 0);
      step("pop_f", 0, 1, E_FETCH);
      step("pop_d", 0, 1, E_DEC);
      step("pop_e", 0, 1, mk(0,0,0, 0,0,0,0, 0,0, 0,0,0, 0, 2,0,0,0));
      step("pop_m", 0, 1, mk(0,0,0, 0,0,0,0, 0,0, 1,0,2, 1, 3,0,0,0));
      step("pop_w", 0, 1, mk(0,0,0, 0,0,1,1, 0,0, 0,0,0, 0, 4,0,0,0));

      ir(4, 0, 0, 0);
      step("mov_f", 0, 1, E_FETCH);
      step("mov_d", 0, 1, E_DEC);
      step("mov_e", 0, 1, mk(0,0,0, 0,0,0,0, 0,0, 0,0,0, 0, 2,0,0,0));
      step("mov_w", 0, 1, mk(0,0,0, 0,0,1,2, 0,0, 0,0,0, 0, 4,0,0,0));

      ir(6, 5'b00101, 0, 0);
      step("salu_f", 0, 1, E_FETCH);
      step("salu_d", 0, 1, E_DEC);
      step("salu_e", 0, 1, mk(0,0,0, 0,0,0,0, 5,1, 0,0,0, 3, 2,0,0,0));

      ir(5, 0, 0, 1);
      step("nop_f", 0, 1, E_FETCH);
      step("nop_d", 0, 1, E_DEC);

      ir(7, 0, 0, 0);
      step("ill_f", 0, 1, E_FETCH);
      step("ill_d", 0, 1, mk(0,0,0, 1,1,0,0, 0,0, 0,0,0, 0, 1,0,0,1));
      ir(5, 0, 0, 1);
      step("ill_next_f", 0, 1, E_FETCH);
      step("ill_next_d", 0, 1, E_DEC);

      // Ready on the sixteenth request cycle still completes the fetch.
      for (int i = 0; i < 15; i++)
         step("edge_wait", 0, 0, E_WAITF);
      step("edge_f", 0, 1, E_FETCH);
      step("edge_d", 0, 1, E_DEC);

      ir(5, 0, 0, 0);
      step("hlt_f", 0, 1, E_FETCH);
      step("hlt_d", 0, 1, E_DEC);
      step("hlt_h0", 0, 1, mk(0,0,0, 0,0,0,0, 0,0, 0,0,0, 0, 5,1,0,0));
      step("hlt_h1", 0, 1, mk(0,0,0, 0,0,0,0, 0,0, 0,0,0, 0, 5,1,0,0));
      step("hlt_rst", 1, 1, '0);

      ir(5, 0, 0, 1);
      for (int i = 0; i < 16; i++)
         step("to_wait", 0, 0, E_WAITF);
      step("to_h0", 0, 1, mk(0,0,0, 0,0,0,0, 0,0, 0,0,0, 0, 5,1,1,0));
      step("to_h1", 0, 1, mk(0,0,0, 0,0,0,0, 0,0, 0,0,0, 0, 5,1,1,0));
      step("to_rst", 1, 1, '0);

      ir(1, 0, 0, 0);
      step("ar_f", 0, 1, E_FETCH);
      step("ar_d", 0, 1, E_DEC);
      step("ar_e", 0, 1, mk(0,0,0, 0,0,0,0, 0,1, 0,0,0, 0, 2,0,0,0));
      step("ar_mwait0", 0, 0, mk(0,0,0, 0,0,0,0, 0,0, 1,0,1, 0, 3,0,0,0));
      step("ar_mwait1", 0, 0, mk(0,0,0, 0,0,0,0, 0,0, 1,0,1, 0, 3,0,0,0));
      step("ar_rst", 1, 0, '0);
      step("ar_rel_f", 0, 0, E_WAITF);

      for (int i = 0; i < 4 && q.size() > 0; i++)
         @(posedge clk);
      if (q.size() > 0) begin
         errors++;
         checks++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
